// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: oversampling constants, FSM encoding and majority vote shared by the receiver
package uart_rx_pkg;
  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_T0 = 4'd7;
  localparam logic [3:0] SAMPLE_T1 = 4'd8;
  localparam logic [3:0] SAMPLE_T2 = 4'd9;
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bus from the receiver (master) to its consumer (slave)
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data;
  logic data_strobe;
  logic framing_error;
  logic busy;
  modport master (output data, data_strobe, framing_error, busy);
  modport slave (input data, data_strobe, framing_error, busy);
endinterface

// File: rtl/uart_rx_serial_sync.sv
// serial_sync: N-flop synchronizer for an asynchronous pin with a selectable reset value
module serial_sync #(parameter int N = 2) (
  input  logic mclk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff;
  always_ff @(posedge mclk)
    ff <= reset ? {N{rst_val}} : {ff[N-2:0], d};
  assign q = ff[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver, x16 oversampling with 2-of-3 mid-bit majority vote
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 8
) (
  input  logic      mclk,
  input  logic      reset,
  input  logic      baud_x16,
  input  logic      serial,
  uart_rx_if.master rx
);
  localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  state_t state, state_n;
  logic line, mid, wrap, maj;
  logic [3:0] tick, tick_n;
  logic [IW-1:0] idx, idx_n;
  logic [1:0] samp, samp_n;
  logic [DATA_BITS-1:0] sr, sr_n, data_q, data_n;
  logic strobe_q, strobe_n, fe_q, fe_n;
  serial_sync #(.N(SYNC_STAGES)) u_sync (
    .mclk    (mclk),
    .reset   (reset),
    .rst_val (1'b1),
    .d       (serial),
    .q       (line)
  );
  assign mid  = baud_x16 && tick == SAMPLE_T2;
  assign wrap = baud_x16 && tick == LAST_TICK;
  assign maj  = majority(samp[0], samp[1], line);
  always_comb begin
    state_n  = state;
    tick_n   = tick;
    idx_n    = idx;
    samp_n   = samp;
    sr_n     = sr;
    data_n   = data_q;
    strobe_n = 1'b0;
    fe_n     = 1'b0;
    if (baud_x16) begin
      tick_n    = tick + 4'd1;
      samp_n[0] = tick == SAMPLE_T0 ? line : samp[0];
      samp_n[1] = tick == SAMPLE_T1 ? line : samp[1];
      case (state)
        IDLE: begin
          tick_n  = '0;
          state_n = line ? IDLE : START;
        end
        START: begin
          if (mid && maj) state_n = IDLE;
          else if (wrap) begin
            state_n = DATA;
            idx_n   = '0;
          end
        end
        DATA: begin
          if (mid) sr_n = {maj, sr[DATA_BITS-1:1]};
          if (wrap) begin
            state_n = idx == IW'(DATA_BITS - 1) ? STOP : DATA;
            idx_n   = idx == IW'(DATA_BITS - 1) ? idx : idx + 1'b1;
          end
        end
        STOP: begin
          if (mid) begin
            state_n  = maj ? IDLE : BREAK;
            data_n   = maj ? sr : data_q;
            strobe_n = maj;
            fe_n     = !maj;
          end
        end
        BREAK: state_n = line ? IDLE : BREAK;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge mclk) begin
    if (reset) begin
      state    <= IDLE;
      tick     <= '0;
      idx      <= '0;
      samp     <= 2'b11;
      sr       <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      idx      <= idx_n;
      samp     <= samp_n;
      sr       <= sr_n;
      data_q   <= data_n;
      strobe_q <= strobe_n;
      fe_q     <= fe_n;
    end
  end
  assign rx.data          = data_q;
  assign rx.data_strobe   = strobe_q;
  assign rx.framing_error = fe_q;
  assign rx.busy          = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench driving 8N1 frames (nominal, skewed, glitched, broken) into uart_rx
module tb_uart_rx;
  localparam int CLK = 100;
  localparam int BIT = 32 * CLK;
  localparam int FAST = BIT * 97 / 100;
  localparam int SLOW = BIT * 103 / 100;
  logic mclk = 1'b0;
  logic reset = 1'b1;
  logic baud_x16 = 1'b0;
  logic serial = 1'b1;
  logic rst_q = 1'b1;
  logic [7:0] prev_data = '0;
  logic [7:0] last_good = '0;
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int fe_seen = 0;
  int fe_exp = 0;
  uart_rx_if #(.DATA_BITS(8)) ifc ();
  uart_rx #(.SYNC_STAGES(2), .DATA_BITS(8)) dut (
    .mclk     (mclk),
    .reset    (reset),
    .baud_x16 (baud_x16),
    .serial   (serial),
    .rx       (ifc)
  );
  always #(CLK / 2) mclk = ~mclk;
  always @(posedge mclk) baud_x16 <= ~baud_x16;
  always @(posedge mclk) rst_q <= reset;
  always @(negedge mclk) begin
    if (ifc.data_strobe || ifc.framing_error) begin
      checks++;
      if (ifc.data_strobe && ifc.framing_error) begin
        failures++;
        $display("FAIL exclusive strobe=1 framing_error=1 required not both");
      end
    end
    if (ifc.data_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe data=%02h required no strobe", ifc.data);
      end else begin
        last_good = exp_q.pop_front();
        if (ifc.data !== last_good) begin
          failures++;
          $display("FAIL rx_byte data=%02h required %02h", ifc.data, last_good);
        end
      end
    end else if (!rst_q && ifc.data !== prev_data) begin
      checks++;
      failures++;
      $display("FAIL data_stable data=%02h required %02h", ifc.data, prev_data);
    end
    if (ifc.framing_error) fe_seen++;
    prev_data = ifc.data;
  end
  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int period, input int glitch);
    if (stop) exp_q.push_back(b);
    else fe_exp++;
    serial = 1'b0;
    #(period);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        serial = 1'b1;
        #(period / 2 - CLK);
        serial = 1'b0;
        #(2 * CLK);
        serial = 1'b1;
        #(period / 2 - CLK);
      end else begin
        serial = b[i];
        #(period);
      end
    end
    serial = stop;
    #(period);
  endtask
  task automatic settle(input string name);
    int n = 0;
    repeat (20) @(negedge mclk);
    while (ifc.busy && n < 4000) begin
      @(negedge mclk);
      n++;
    end
    expect_eq({name, "_busy"}, int'(ifc.busy), 0);
    expect_eq({name, "_pending"}, exp_q.size(), 0);
    expect_eq({name, "_framing"}, fe_seen, fe_exp);
  endtask
  task automatic expect_reset_outputs(input string name);
    expect_eq({name, "_data"}, int'(ifc.data), 0);
    expect_eq({name, "_strobe"}, int'(ifc.data_strobe), 0);
    expect_eq({name, "_fe"}, int'(ifc.framing_error), 0);
    expect_eq({name, "_busy"}, int'(ifc.busy), 0);
  endtask
  initial begin
    repeat (5) @(negedge mclk);
    expect_reset_outputs("reset");
    reset = 1'b0;
    repeat (10) @(negedge mclk);
    #23;
    send(8'h41, 1'b1, BIT, -1);
    settle("single");
    #(2 * BIT);
    send(8'h0D, 1'b1, BIT, -1);
    send(8'h0A, 1'b1, BIT, -1);
    settle("back_to_back");
    #(BIT);
    serial = 1'b0;
    #(8 * CLK);
    serial = 1'b1;
    #(2 * BIT);
    settle("false_start");
    send(8'hFF, 1'b1, BIT, int'($urandom_range(0, 7)));
    settle("glitch_ff");
    #(BIT);
    send(8'h55, 1'b0, BIT, -1);
    #(40 * BIT);
    expect_eq("break_data_kept", int'(ifc.data), int'(last_good));
    expect_eq("break_busy", int'(ifc.busy), 1);
    serial = 1'b1;
    #(2 * BIT);
    settle("break");
    send(8'h33, 1'b1, BIT, -1);
    settle("after_break");
    #(BIT);
    serial = 1'b0;
    #(BIT);
    for (int i = 0; i < 4; i++) begin
      serial = i[0];
      #(BIT);
    end
    serial = 1'b0;
    #(BIT / 2);
    @(negedge mclk);
    reset = 1'b1;
    serial = 1'b1;
    @(negedge mclk);
    reset = 1'b0;
    expect_reset_outputs("mid_reset");
    last_good = '0;
    #(3 * BIT + 23);
    settle("mid_reset_quiet");
    send(8'h5A, 1'b1, BIT, -1);
    settle("after_reset");
    for (int i = 0; i < 256; i++) begin
      if (i < 128) begin
        send(8'(i), 1'b1, SLOW, -1);
        #($urandom_range(0, 4 * CLK));
      end else begin
        send(8'(i), 1'b1, FAST, -1);
        #(8 * CLK + $urandom_range(0, 4 * CLK));
      end
    end
    settle("loopback");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
